bus_arbiter_rr: RTL and testbench
=================================

# bus_arbiter_rr

Two-master round-robin bus arbiter with bounded grant hold. It is registered and Moore-style, and replaces the free-running arbitrator in front of the shared 8-bit-address / 32-bit-data bus. `M0_grant` drives the bus master-side mux selects directly. The hold limit guarantees that neither master can starve the other.

## Interface
Parameters:
- `HOLD_MAX`, default 16: maximum consecutive grant cycles while the other master is requesting. Must be ≥1.
- `CNT_W`, default 5: hold counter width. Must satisfy 2^CNT_W > HOLD_MAX-1.

Ports:
- `clk`  in  1  system clock. Everything is on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `M0_req`  in  1  master 0 bus request, level.
- `M1_req`  in  1  master 1 bus request, level.
- `M0_grant`  out  1  master 0 owns the bus.
- `M1_grant`  out  1  master 1 owns the bus.
- `bus_busy`  out  1  either grant is active.
- `last_owner`  out  1  last master granted (0/1), used for the tie-break.
- `hold_cnt`  out  CNT_W  cycles elapsed in the current grant, saturating.

## Operation
- Three states: IDLE, GRANT0, GRANT1. Grants decode from the state register only, and are never both 1.
- **IDLE**
  - Both requesting: go to the GRANT state of the master ≠ `last_owner`.
  - One requesting: go to that master's GRANT state.
  - None requesting: stay in IDLE.
- **GRANTx**, in priority order:
  - `Mx_req`=0 and the other master requesting: go to GRANTother. There is no IDLE bubble.
  - `Mx_req`=0 and no other request: go to IDLE.
  - `Mx_req`=1, other requesting, and `hold_cnt`==HOLD_MAX-1: preempt and go to GRANTother.
  - Otherwise: stay in GRANTx.
- `hold_cnt`:
  - Cleared on every transition into a GRANT state, and while in IDLE.
  - Increments each cycle spent in a GRANT state, saturating at HOLD_MAX-1.
  - An uncontested owner keeps the bus indefinitely. The count only forces a handoff when the other master is requesting.
- `last_owner` updates on entry to a GRANT state.
- Reset values:
  - state = IDLE
  - `M0_grant` = `M1_grant` = `bus_busy` = 0
  - `hold_cnt` = 0
  - `last_owner` = 1, so M0 wins the first tie.
- HOLD_MAX=1: contended grants alternate every cycle.

## Timing
- Request latency: `Mx_req` sampled high at edge n gives `Mx_grant` high after edge n. This is one cycle from the request.
- Release latency: `Mx_req` sampled low at edge n gives `Mx_grant` low after edge n. If the other master is requesting, its grant rises at the same edge.
- Preemption: the owner holds for exactly HOLD_MAX cycles under continuous contention.
- Simultaneous release by the owner and request by the other master: a clean handoff with zero idle cycles.
- Both masters dropping their requests in the same cycle: go to IDLE.
- `reset` high at any edge, including mid-grant: state goes to IDLE and all outputs take their reset values after that edge. Requests are ignored while `reset`=1.
- All outputs are glitch-free registered or state decodes. There is no combinational path from the requests to the grants.

## Structure
- Package `bus_arb_pkg`:
  - State encoding constants: ST_IDLE=2'b00, ST_GRANT0=2'b01, ST_GRANT1=2'b10.
  - Master index constants: M0=1'b0, M1=1'b1.
- Sub-module `arb_hold_cnt`: a saturating CNT_W counter with `clr`/`en` inputs and a `max` flag (count==HOLD_MAX-1).
- The top level holds the FSM and `last_owner`.

## Test plan
1. Reset, then `M0_req`=1 at cycle 2 → `M0_grant`=1 from cycle 3, `last_owner`=0, `hold_cnt` counts 0,1,2….
2. Both requests raised together from IDLE after reset → M0 granted first (`last_owner` reset=1). Release M0 → `M1_grant` rises the same edge `M0_grant` falls, no IDLE cycle.
3. HOLD_MAX=4, both requests held high → grants alternate M0×4, M1×4, M0×4; `hold_cnt` sequence 0,1,2,3,0….
4. M1 alone holds `M1_req` for 40 cycles → `M1_grant` stays high, `hold_cnt` saturates at 15, no preemption.
5. `reset` asserted while GRANT1 with `hold_cnt`=7 → after the next edge, grants=0, `hold_cnt`=0, `last_owner`=1. On release with both requesting → M0 granted.
6. HOLD_MAX=1, both requesting → grants toggle every cycle, never both high, `bus_busy` constant 1.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master round-robin bus arbiter.
// Includes the state encoding, the master indices and a small helper.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GRANT0 = 2'b01,
      ST_GRANT1 = 2'b10
   } arb_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // Maps a master index to the state in which that master owns the bus.
   function automatic arb_state_t grant_state(input logic idx);
      return (idx == M1) ? ST_GRANT1 : ST_GRANT0;
   endfunction

endpackage

// File: rtl/arb_hold_cnt.sv
// Saturating grant-hold counter. It counts cycles spent in one grant and raises max
// at HOLD_MAX-1. clr has priority over en.
module arb_hold_cnt #(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             max
);

   localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(HOLD_MAX - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_max;

   assign w_at_max = (r_cnt == LP_CNT_MAX);
   assign cnt      = r_cnt;
   assign max      = w_at_max;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_cnt <= '0;
      end else if (en && !w_at_max) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Two-master round-robin bus arbiter with bounded grant hold. All outputs are registered,
// and the grants follow the next state, so no request reaches a grant combinationally.
module bus_arbiter_rr
   import bus_arb_pkg::*;
#(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             M0_req,
   input  logic             M1_req,
   output logic             M0_grant,
   output logic             M1_grant,
   output logic             bus_busy,
   output logic             last_owner,
   output logic [CNT_W-1:0] hold_cnt
);

   arb_state_t r_state;
   arb_state_t w_next_state;
   logic       r_m0_grant;
   logic       r_m1_grant;
   logic       r_bus_busy;
   logic       r_last_owner;
   logic       w_hold_max;
   logic       w_cnt_clr;
   logic       w_cnt_en;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            // On a tie, the master that did not own the bus last wins.
            if (M0_req && M1_req)
               w_next_state = grant_state(~r_last_owner);
            else if (M0_req)
               w_next_state = ST_GRANT0;
            else if (M1_req)
               w_next_state = ST_GRANT1;
         end
         ST_GRANT0: begin
            if (!M0_req)
               w_next_state = M1_req ? ST_GRANT1 : ST_IDLE;
            else if (M1_req && w_hold_max)
               w_next_state = ST_GRANT1;
         end
         ST_GRANT1: begin
            if (!M1_req)
               w_next_state = M0_req ? ST_GRANT0 : ST_IDLE;
            else if (M0_req && w_hold_max)
               w_next_state = ST_GRANT0;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // The count restarts on every grant entry and stays at zero in IDLE.
   assign w_cnt_clr = (w_next_state == ST_IDLE) || (w_next_state != r_state);
   assign w_cnt_en  = ~w_cnt_clr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_m0_grant   <= 1'b0;
         r_m1_grant   <= 1'b0;
         r_bus_busy   <= 1'b0;
         r_last_owner <= M1;
      end else begin
         r_state    <= w_next_state;
         r_m0_grant <= (w_next_state == ST_GRANT0);
         r_m1_grant <= (w_next_state == ST_GRANT1);
         r_bus_busy <= (w_next_state == ST_GRANT0) || (w_next_state == ST_GRANT1);
         if (w_next_state == ST_GRANT0)
            r_last_owner <= M0;
         else if (w_next_state == ST_GRANT1)
            r_last_owner <= M1;
      end
   end

   arb_hold_cnt #(
      .HOLD_MAX (HOLD_MAX),
      .CNT_W    (CNT_W)
   ) u_hold_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (w_cnt_clr),
      .en    (w_cnt_en),
      .cnt   (hold_cnt),
      .max   (w_hold_max)
   );

   assign M0_grant   = r_m0_grant;
   assign M1_grant   = r_m1_grant;
   assign bus_busy   = r_bus_busy;
   assign last_owner = r_last_owner;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr with three instances: HOLD_MAX=16, 4 and 1.
// All three instances share the same request and reset stimulus.
module tb_bus_arbiter_rr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic m0_req;
   logic m1_req;

   logic       g0_a, g1_a, busy_a, last_a;
   logic [4:0] cnt_a;
   logic       g0_b, g1_b, busy_b, last_b;
   logic [4:0] cnt_b;
   logic       g0_c, g1_c, busy_c, last_c;
   logic [4:0] cnt_c;

   int n_checks = 0;
   int n_errors = 0;

   bus_arbiter_rr dut_a (
      .clk(clk), .reset(rst), .M0_req(m0_req), .M1_req(m1_req),
      .M0_grant(g0_a), .M1_grant(g1_a), .bus_busy(busy_a),
      .last_owner(last_a), .hold_cnt(cnt_a)
   );

   bus_arbiter_rr #(.HOLD_MAX(4), .CNT_W(5)) dut_b (
      .clk(clk), .reset(rst), .M0_req(m0_req), .M1_req(m1_req),
      .M0_grant(g0_b), .M1_grant(g1_b), .bus_busy(busy_b),
      .last_owner(last_b), .hold_cnt(cnt_b)
   );

   bus_arbiter_rr #(.HOLD_MAX(1), .CNT_W(5)) dut_c (
      .clk(clk), .reset(rst), .M0_req(m0_req), .M1_req(m1_req),
      .M0_grant(g0_c), .M1_grant(g1_c), .bus_busy(busy_c),
      .last_owner(last_c), .hold_cnt(cnt_c)
   );

   typedef struct {
      logic       rst;
      logic       m0;
      logic       m1;
      logic       g0;
      logic       g1;
      logic       last;
      logic [4:0] cnt;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic r, input logic a, input logic b,
                               input logic e0, input logic e1, input logic el,
                               input logic [4:0] ec);
      vec_t v;
      v.rst = r; v.m0 = a; v.m1 = b;
      v.g0 = e0; v.g1 = e1; v.last = el; v.cnt = ec;
      return v;
   endfunction

   function automatic logic [8:0] pk(input logic e0, input logic e1, input logic el,
                                     input logic [4:0] ec);
      return {e0, e1, e0 | e1, el, ec};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int step, input logic [8:0] act,
                        input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got g0=%b g1=%b busy=%b last=%b cnt=%0d, want g0=%b g1=%b busy=%b last=%b cnt=%0d",
                  tag, step, act[8], act[7], act[6], act[5], act[4:0],
                  exp[8], exp[7], exp[6], exp[5], exp[4:0]);
      end
   endtask

   initial begin
      rst    = 1'b1;
      m0_req = 1'b0;
      m1_req = 1'b0;

      //               rst   m0    m1    g0    g1    last  cnt
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
      vecs[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
      vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
      vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
      vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
      vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
      vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1);
      vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      vecs[14] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
      vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);

      for (int i = 0; i < 16; i++) begin
         rst    = vecs[i].rst;
         m0_req = vecs[i].m0;
         m1_req = vecs[i].m1;
         tick();
         check("table", i, {g0_a, g1_a, busy_a, last_a, cnt_a},
               pk(vecs[i].g0, vecs[i].g1, vecs[i].last, vecs[i].cnt));
      end

      // M1 alone for 40 cycles: the count saturates and M1 is never preempted.
      m1_req = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         check("m1_alone", k, {g0_a, g1_a, busy_a, last_a, cnt_a},
               pk(1'b0, 1'b1, 1'b1, 5'((k > 15) ? 15 : k)));
      end
      // A request arriving at a saturated count preempts M1 at the next edge.
      m0_req = 1'b1;
      tick();
      check("preempt_sat", 0, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b1, 1'b0, 1'b0, 5'd0));
      for (int k = 1; k < 16; k++) begin
         tick();
         check("hold16", k, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b1, 1'b0, 1'b0, 5'(k)));
      end
      tick();
      check("hold16", 16, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b0, 1'b1, 1'b1, 5'd0));
      m0_req = 1'b0;
      m1_req = 1'b0;
      tick();
      check("drop_both", 0, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b0, 1'b0, 1'b1, 5'd0));

      // Reset in the middle of a GRANT1 with hold_cnt=7.
      m1_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("pre_reset", k, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b0, 1'b1, 1'b1, 5'(k)));
      end
      rst    = 1'b1;
      m0_req = 1'b1;
      tick();
      check("mid_reset", 0, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b0, 1'b0, 1'b1, 5'd0));
      rst = 1'b0;
      tick();
      check("post_reset", 0, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b1, 1'b0, 1'b0, 5'd0));
      m0_req = 1'b0;
      m1_req = 1'b0;
      tick();
      check("post_reset", 1, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b0, 1'b0, 1'b0, 5'd0));

      // Continuous contention on all three instances after a common reset.
      rst = 1'b1;
      tick();
      check("rst_a", 0, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b0, 1'b0, 1'b1, 5'd0));
      check("rst_b", 0, {g0_b, g1_b, busy_b, last_b, cnt_b}, pk(1'b0, 1'b0, 1'b1, 5'd0));
      check("rst_c", 0, {g0_c, g1_c, busy_c, last_c, cnt_c}, pk(1'b0, 1'b0, 1'b1, 5'd0));
      rst    = 1'b0;
      m0_req = 1'b1;
      m1_req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         logic ob;
         logic oc;
         ob = (((k / 4) % 2) == 1);
         oc = ((k % 2) == 1);
         tick();
         check("contend16", k, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b1, 1'b0, 1'b0, 5'(k)));
         check("contend4", k, {g0_b, g1_b, busy_b, last_b, cnt_b}, pk(~ob, ob, ob, 5'(k % 4)));
         check("contend1", k, {g0_c, g1_c, busy_c, last_c, cnt_c}, pk(~oc, oc, oc, 5'd0));
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      tick();
      check("idle_a", 0, {g0_a, g1_a, busy_a, last_a, cnt_a}, pk(1'b0, 1'b0, 1'b0, 5'd0));
      check("idle_b", 0, {g0_b, g1_b, busy_b, last_b, cnt_b}, pk(1'b0, 1'b0, 1'b0, 5'd0));
      check("idle_c", 0, {g0_c, g1_c, busy_c, last_c, cnt_c}, pk(1'b0, 1'b0, 1'b1, 5'd0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
